// File: rtl/metric_mem_sequencer.sv
// Sequences one Viterbi trellis stage: metric-memory reads, delayed write-back of ACS results,
// ping-pong block swap and normalization signalling between stages.
module metric_mem_sequencer #(
  parameter int WD_METR = 8,
  parameter int N_ACS   = 4,
  parameter int ACS_LAT = 2
) (
  input  logic                       Clock1,
  input  logic                       Reset,
  input  logic                       Active,
  input  logic                       SymValid,
  input  logic [WD_METR*N_ACS-1:0]   ACSMetric,
  output logic [4:0]                 MMReadAddress,
  output logic [5:0]                 MMWriteAddress,
  output logic                       MMWriteEnable,
  output logic [WD_METR*N_ACS-1:0]   MMMetric,
  output logic                       MMBlockSelect,
  output logic                       Normalize,
  output logic                       Busy,
  output logic                       StageDone,
  output logic                       Overrun
);

  localparam int         WORD_W     = WD_METR * N_ACS;
  localparam logic [6:0] RUN_LAST   = 7'd63;
  localparam logic [6:0] WIN_FIRST  = 7'(ACS_LAT);
  localparam logic [6:0] WIN_LAST   = 7'(63 + ACS_LAT);
  localparam logic [6:0] DRAIN_LAST = 7'(64 + ACS_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;

  state_t              state_reg;
  logic [6:0]          cnt_reg;
  logic                pending_reg;
  logic                overrun_reg;
  logic                norm_flag_reg;
  logic                normalize_reg;
  logic                bsel_reg;
  logic                done_reg;
  logic                we_reg;
  logic [5:0]          waddr_reg;
  logic [WORD_W-1:0]   metric_reg;
  logic [N_ACS-1:0]    lane_msb;
  logic [5:0]          widx;
  logic                sample_win;

  genvar gi;
  generate
    for (gi = 0; gi < N_ACS; gi++) begin : g_lane
      assign lane_msb[gi] = ACSMetric[gi*WD_METR + WD_METR - 1];
    end
  endgenerate

  // Stage cycle cnt carries the ACS result for write index cnt-ACS_LAT.
  always_comb begin
    widx       = cnt_reg[5:0] - 6'(ACS_LAT);
    sample_win = (state_reg == RUN || state_reg == DRAIN) &&
                 (cnt_reg >= WIN_FIRST) && (cnt_reg <= WIN_LAST);
  end

  always_ff @(posedge Clock1 or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pending_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
      norm_flag_reg <= 1'b0;
      normalize_reg <= 1'b0;
      bsel_reg      <= 1'b0;
      done_reg      <= 1'b0;
      we_reg        <= 1'b0;
      waddr_reg     <= '0;
      metric_reg    <= '0;
    end else if (Active) begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      if (sample_win) begin
        we_reg        <= 1'b1;
        metric_reg    <= ACSMetric;
        // Even indices fill the lower half, odd indices the upper half.
        waddr_reg     <= {widx[0], widx[5:1]};
        norm_flag_reg <= norm_flag_reg | (|lane_msb);
      end
      if (SymValid && (state_reg == RUN || state_reg == DRAIN)) begin
        if (pending_reg) overrun_reg <= 1'b1;
        else             pending_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (SymValid) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 7'd1;
          if (cnt_reg == RUN_LAST) state_reg <= DRAIN;
        end
        DRAIN: begin
          cnt_reg <= cnt_reg + 7'd1;
          if (cnt_reg == DRAIN_LAST) begin
            state_reg <= SWAP;
            done_reg  <= 1'b1;
          end
        end
        SWAP: begin
          bsel_reg      <= ~bsel_reg;
          normalize_reg <= norm_flag_reg;
          norm_flag_reg <= 1'b0;
          cnt_reg       <= '0;
          // A request arriving in SWAP itself is treated like one already pending.
          if (pending_reg || SymValid) begin
            state_reg   <= RUN;
            pending_reg <= pending_reg & SymValid;
          end else begin
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MMReadAddress  = (state_reg == RUN) ? cnt_reg[5:1] : 5'd0;
  assign MMWriteAddress = waddr_reg;
  assign MMWriteEnable  = we_reg & Active;
  assign MMMetric       = metric_reg;
  assign MMBlockSelect  = bsel_reg;
  assign Normalize      = normalize_reg;
  assign Busy           = (state_reg != IDLE);
  assign StageDone      = done_reg & Active;
  assign Overrun        = overrun_reg;

endmodule

// File: tb/tb_metric_mem_sequencer.sv
// Randomized bench for metric_mem_sequencer against a stage-level schedule model
// indexed by enabled (Active=1) cycles.
module tb_metric_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic        sym_valid;
  logic [31:0] acs_metric;
  logic [4:0]  rd_addr;
  logic [5:0]  wr_addr;
  logic        wr_en;
  logic [31:0] mm_metric;
  logic        bsel;
  logic        normalize;
  logic        busy;
  logic        stage_done;
  logic        overrun;

  metric_mem_sequencer #(.WD_METR(8), .N_ACS(4), .ACS_LAT(2)) dut (
    .Clock1         (clk),
    .Reset          (rst),
    .Active         (active),
    .SymValid       (sym_valid),
    .ACSMetric      (acs_metric),
    .MMReadAddress  (rd_addr),
    .MMWriteAddress (wr_addr),
    .MMWriteEnable  (wr_en),
    .MMMetric       (mm_metric),
    .MMBlockSelect  (bsel),
    .Normalize      (normalize),
    .Busy           (busy),
    .StageDone      (stage_done),
    .Overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: t = index of the current enabled cycle; a stage occupies t in [start, start+67].
  int          t          = 0;
  int          cur_start  = -1;
  bit          pending    = 0;
  bit          ovr        = 0;
  int          done_count = 0;
  bit          norm_acc   = 0;
  bit          norm_out   = 0;
  int          msb_div    = 0;
  int          inject_t   = -1;
  logic [31:0] hist [0:4095];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, got, exp);
    end
  endtask

  task automatic reset_outputs_check();
    check("rst_raddr", rd_addr, 0);
    check("rst_waddr", wr_addr, 0);
    check("rst_we", wr_en, 0);
    check("rst_metric", mm_metric, 0);
    check("rst_bsel", bsel, 0);
    check("rst_norm", normalize, 0);
    check("rst_busy", busy, 0);
    check("rst_done", stage_done, 0);
    check("rst_ovr", overrun, 0);
  endtask

  task automatic model_reset();
    cur_start  = -1;
    pending    = 0;
    ovr        = 0;
    done_count = 0;
    norm_acc   = 0;
    norm_out   = 0;
  endtask

  task automatic step(input bit sv, input bit act);
    logic [31:0] d;
    int k, w;
    bit in_stage, e_we, e_done;
    d = $urandom & 32'h7f7f7f7f;
    if (msb_div > 0 && $urandom_range(0, msb_div - 1) == 0)
      d = d | (32'h80 << (8 * $urandom_range(0, 3)));
    if (act && t == inject_t) d = 32'h00800000;
    @(posedge clk);
    #1;
    active     = act;
    sym_valid  = sv;
    acs_metric = d;
    if (act) hist[t] = d;
    @(negedge clk);
    k        = (cur_start >= 0) ? t - cur_start : -1;
    in_stage = (k >= 0 && k <= 67);
    e_we     = act && k >= 3 && k <= 66;
    e_done   = act && k == 67;
    check("busy", busy, in_stage);
    check("raddr", rd_addr, (in_stage && k < 64) ? (k >> 1) : 0);
    check("we", wr_en, e_we);
    check("done", stage_done, e_done);
    check("bsel", bsel, done_count % 2);
    check("norm", normalize, norm_out);
    check("ovr", overrun, ovr);
    if (e_we) begin
      w = k - 3;
      check("waddr", wr_addr, (w >> 1) + (w % 2) * 32);
      check("wdata", mm_metric, hist[cur_start + w + 2]);
      if ((hist[cur_start + w + 2] & 32'h80808080) != 0) norm_acc = 1;
    end
    if (act) begin
      if (k == 67) begin
        done_count++;
        norm_out = norm_acc;
        norm_acc = 0;
        if (pending || sv) begin
          cur_start = t + 1;
          pending   = pending && sv;
        end else begin
          cur_start = -1;
        end
      end else if (in_stage) begin
        if (sv) begin
          if (pending) ovr = 1;
          else         pending = 1;
        end
      end else if (sv) begin
        cur_start = t + 1;
      end
      t++;
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    sym_valid = 1'b0;
    #1;
    reset_outputs_check();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    active     = 1'b0;
    sym_valid  = 1'b0;
    acs_metric = '0;
    @(negedge clk);
    reset_outputs_check();
    @(negedge clk);
    rst = 1'b0;

    repeat (3) step(0, 1);

    // Single stage.
    step(1, 1);
    repeat (75) step(0, 1);

    // Back-to-back stages; stage 1 carries one MSB-set word, stage 2 none.
    inject_t = t + 10;
    step(1, 1);
    repeat (9) step(0, 1);
    step(1, 1);
    repeat (150) step(0, 1);

    // Three requests in one stage.
    step(1, 1);
    repeat (9) step(0, 1);
    step(1, 1);
    repeat (9) step(0, 1);
    step(1, 1);
    repeat (150) step(0, 1);

    // Reset at stage cycle 30.
    step(1, 1);
    repeat (30) step(0, 1);
    mid_reset();
    repeat (20) step(0, 1);

    // Freeze for 5 cycles at stage cycle 20.
    step(1, 1);
    repeat (20) step(0, 1);
    repeat (5) step(0, 0);
    repeat (60) step(0, 1);

    // Random traffic with pauses and sparse MSB-set words.
    msb_div = 300;
    repeat (1500) step($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0);
    repeat (80) step(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/metric_mem_sequencer.md
METRIC_MEM_SEQUENCER -- requirements
Module: metric_mem_sequencer

Interface
REQ-001 Parameter WD_METR, 8, width of one path metric.
REQ-002 Parameter N_ACS, 4, metrics per memory word (word = WD_METR*N_ACS = 32 bits).
REQ-003 Parameter ACS_LAT, 2, cycles from MMReadAddress issue to matching ACSMetric valid.
REQ-004 Clock1  in  1  single clock; all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 Active  in  1  global enable; 0 freezes all state.
REQ-007 SymValid  in  1  one-cycle pulse requesting one trellis stage.
REQ-008 ACSMetric  in  WD_METR*N_ACS  new-metric word from ACS array.
REQ-009 MMReadAddress  out  5  metric-memory read address (64-bit pair).
REQ-010 MMWriteAddress  out  6  metric-memory write address (32-bit word).
REQ-011 MMWriteEnable  out  1  write strobe to metric memory.
REQ-012 MMMetric  out  WD_METR*N_ACS  write data to metric memory.
REQ-013 MMBlockSelect  out  1  ping-pong select; 0 = write A/read B, 1 = write B/read A.
REQ-014 Normalize  out  1  ACS shall subtract normalization offset this stage.
REQ-015 Busy  out  1  high whenever FSM not IDLE.
REQ-016 StageDone  out  1  one-cycle pulse at end of each stage.
REQ-017 Overrun  out  1  sticky: a stage request was dropped.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, SWAP.
REQ-019 IDLE + SymValid (Active=1) -> RUN next cycle, RUN cycle counter c=0.
REQ-020 RUN lasts exactly 64 cycles, c=0..63; MMReadAddress = c>>1; outside RUN MMReadAddress = 0.
REQ-021 ACSMetric for write index w SHALL be sampled at end of stage cycle w+ACS_LAT (stage cycle counted from first RUN cycle).
REQ-022 In stage cycle w+ACS_LAT+1: MMWriteEnable=1, MMMetric = sampled word, MMWriteAddress = w>>1 for even w, (w>>1)+32 for odd w.
REQ-023 MMWriteEnable SHALL be 0 in every other cycle; exactly 64 writes per stage.
REQ-024 DRAIN follows RUN for ACS_LAT+1 cycles (stage cycles 64..66 at default), completing outstanding writes.
REQ-025 SWAP lasts 1 cycle: StageDone=1; MMBlockSelect toggles on the edge leaving SWAP.
REQ-026 Stage length SHALL be 68 cycles at default ACS_LAT (64+ACS_LAT+2).
REQ-027 Norm flag: OR of the MSB of each WD_METR lane of every written MMMetric within a stage.
REQ-028 On edge leaving SWAP: Normalize <= norm flag, norm flag <= 0; Normalize held constant for whole next stage.
REQ-029 SymValid while Busy sets one-deep Pending; SymValid with Pending already 1 sets Overrun, pulse dropped.
REQ-030 SWAP with Pending=1 -> RUN (c=0), Pending cleared; otherwise -> IDLE.
REQ-031 SymValid in same SWAP cycle that consumes Pending -> Pending re-set, no Overrun.
REQ-032 Active=0: FSM, counters, sample pipeline, Pending frozen; SymValid ignored; MMWriteEnable and StageDone forced 0; resume exactly where frozen.

Reset
REQ-033 Reset=1 SHALL asynchronously force IDLE, c=0, Pending=0, norm flag=0.
REQ-034 Reset values: MMReadAddress=0, MMWriteAddress=0, MMWriteEnable=0, MMMetric=0, MMBlockSelect=0, Normalize=0, Busy=0, StageDone=0, Overrun=0.
REQ-035 Reset asserted mid-stage SHALL abandon the stage with no further writes; MMBlockSelect returns to 0.

Verification
REQ-036 Single stage: SymValid at t0, ACSMetric=write index -> reads 0,0,1,1..31,31; 64 writes, addr order 0,32,1,33..31,63, data 0..63; StageDone at t0+68; MMBlockSelect 0->1.
REQ-037 Back-to-back: second SymValid at t0+10 -> Pending; next RUN starts cycle after SWAP, no IDLE gap; Overrun stays 0.
REQ-038 Overrun: three SymValid pulses in one stage -> Overrun=1 and sticky; exactly two stages run.
REQ-039 Normalization: one written word 32'h00800000 in stage 1 -> Normalize=1 throughout stage 2; stage-2 data all MSB-clear -> Normalize=0 in stage 3.
REQ-040 Freeze: Active=0 for 5 cycles at stage cycle 20 -> no writes while low, stage completes 5 cycles later, same write sequence.
REQ-041 Reset at stage cycle 30 -> all outputs at reset values immediately; no write after deassertion until new SymValid.
